// File: rtl/dmem_responder_if.sv
// Request/response bundle between a load/store unit (master) and the
// data-memory responder (slave).
interface dmem_responder_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [3:0]        req_wstrb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, byte-masked writes, response after
// a programmable latency. Define DMEM_RAND_DELAY_EN to add 0..3 cycles of LFSR jitter.
module dmem_responder #(
  parameter int                DATA_W     = 32,
  parameter int                DEPTH_LOG2 = 12,
  parameter logic [DATA_W-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                LATENCY    = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  localparam logic [DATA_W-1:0] SPAN = (DATA_W)'(64'd4 << DEPTH_LOG2);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [4:0]        cnt;
  logic              cap_wen;
  logic [DATA_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [3:0]        cap_wstrb;

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  logic                  accept;
  logic [4:0]            eff_lat;
  logic                  do_access;
  logic                  acc_wen;
  logic [DATA_W-1:0]     acc_addr;
  logic [DATA_W-1:0]     acc_wdata;
  logic [3:0]            acc_wstrb;
  logic [DATA_W-1:0]     offset;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] idx;
  logic [DATA_W-1:0]     rd_word;

`ifdef DMEM_RAND_DELAY_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) lfsr <= 8'hA5;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign eff_lat = 5'(LATENCY) + {3'b000, lfsr[1:0]};
`else
  assign eff_lat = 5'(LATENCY);
`endif

  assign accept = (state == IDLE) && bus.req_valid && bus.req_ready;

  // The array access happens on the edge entering RESP; with a one-cycle
  // latency that is the accept edge itself, so the live request is used.
  always_comb begin
    do_access = 1'b0;
    acc_wen   = cap_wen;
    acc_addr  = cap_addr;
    acc_wdata = cap_wdata;
    acc_wstrb = cap_wstrb;
    if (accept && eff_lat == 5'd1) begin
      do_access = 1'b1;
      acc_wen   = bus.req_wen;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
      acc_wstrb = bus.req_wstrb;
    end else if (state == WAIT && cnt == '0) begin
      do_access = 1'b1;
    end
  end

  assign offset   = acc_addr - BASE_ADDR;
  assign in_range = offset < SPAN;
  assign idx      = offset[DEPTH_LOG2+1:2];
  assign rd_word  = mem[idx];

  always_ff @(posedge clk) begin
    if (!rst && do_access && acc_wen && in_range) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (acc_wstrb[i]) mem[idx][i*8 +: 8] <= acc_wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      cap_wen       <= 1'b0;
      cap_addr      <= '0;
      cap_wdata     <= '0;
      cap_wstrb     <= '0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cap_wen       <= bus.req_wen;
            cap_addr      <= bus.req_addr;
            cap_wdata     <= bus.req_wdata;
            cap_wstrb     <= bus.req_wstrb;
            bus.req_ready <= 1'b0;
            if (eff_lat == 5'd1) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_rdata <= (in_range && !acc_wen) ? rd_word : '0;
              bus.rsp_err   <= !in_range;
            end else begin
              cnt   <= eff_lat - 5'd2;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= (in_range && !acc_wen) ? rd_word : '0;
            bus.rsp_err   <= !in_range;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed table-driven bench for dmem_responder plus hand-written sequences
// for back-pressure, reset during WAIT and (optionally) randomised latency.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if #(.DATA_W(32)) bus ();

  dmem_responder #(
    .DATA_W    (32),
    .DEPTH_LOG2(12),
    .BASE_ADDR (32'h8000_0000),
    .LATENCY   (LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[16];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_lat(input string name, input int lat);
`ifdef DMEM_RAND_DELAY_EN
    chk(name, 32'(lat >= LAT && lat <= LAT + 3), 32'd1);
`else
    chk(name, 32'(lat), 32'(LAT));
`endif
  endtask

  // Starts at a negedge; returns at the negedge where rsp_valid is first seen.
  task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, output int lat, output logic [31:0] rd,
                       output logic err, output logic ok);
    int w = 0;
    ok = 1'b0; lat = 0; rd = '0; err = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_wen   = wen;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_wstrb = wstrb;
    while (!bus.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!bus.req_ready) begin
      chk("accept_timeout", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_wen   = ~wen;
    bus.req_addr  = 32'h8000_0030;
    bus.req_wdata = ~wdata;
    bus.req_wstrb = ~wstrb;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1 && !bus.rsp_valid) chk("req_ready_low_wait", 32'(bus.req_ready), 32'd0);
    end while (!bus.rsp_valid && lat < 40);
    if (!bus.rsp_valid) begin
      chk("rsp_timeout", 32'(bus.rsp_valid), 32'd1);
      return;
    end
    rd = bus.rsp_rdata;
    err = bus.rsp_err;
    ok = 1'b1;
  endtask

  // Handshake with rsp_ready already high; check the responder returns to idle.
  task automatic complete(input string name);
    @(posedge clk);
    @(negedge clk);
    chk({name, "_rsp_valid_drop"}, 32'(bus.rsp_valid), 32'd0);
    chk({name, "_req_ready_back"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        err;
    logic        ok;

    vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h8000_0010, 32'h1122_3344, 4'h5, 32'h0,         1'b0};
    vecs[3]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDE22_BE44, 1'b0};
    vecs[4]  = '{1'b1, 32'h8000_0000, 32'h0102_0304, 4'hF, 32'h0,         1'b0};
    vecs[5]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0,         1'b1};
    vecs[6]  = '{1'b0, 32'h8000_4000, 32'h0,         4'h0, 32'h0,         1'b1};
    vecs[7]  = '{1'b1, 32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
    vecs[8]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'h0102_0304, 1'b0};
    vecs[9]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDE22_BE44, 1'b0};
    vecs[10] = '{1'b1, 32'h8000_0010, 32'h5555_5555, 4'h0, 32'h0,         1'b0};
    vecs[11] = '{1'b0, 32'h8000_0013, 32'h0,         4'h0, 32'hDE22_BE44, 1'b0};
    vecs[12] = '{1'b1, 32'h8000_3FFC, 32'hAABB_CCDD, 4'hF, 32'h0,         1'b0};
    vecs[13] = '{1'b0, 32'h8000_3FFC, 32'h0,         4'h0, 32'hAABB_CCDD, 1'b0};
    vecs[14] = '{1'b1, 32'h8000_0020, 32'h0,         4'hF, 32'h0,         1'b0};
    vecs[15] = '{1'b1, 32'h7FFF_FFFC, 32'h1234_5678, 4'hF, 32'h0,         1'b1};

    bus.req_valid = 1'b0;
    bus.req_wen   = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    bus.rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("reset_rsp_err",   32'(bus.rsp_err), 32'd0);

    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, lat, rd, err, ok);
      if (ok) begin
        chk_lat($sformatf("vec%0d_latency", i), lat);
        chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
        chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
        complete($sformatf("vec%0d", i));
      end
    end

    // Back-pressure: response must hold for 5 cycles with rsp_ready low.
    bus.rsp_ready = 1'b0;
    issue(1'b0, 32'h8000_0010, 32'h0, 4'h0, lat, rd, err, ok);
    if (ok) begin
      chk("hold_first_rdata", rd, 32'hDE22_BE44);
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        chk($sformatf("hold%0d_valid", c), 32'(bus.rsp_valid), 32'd1);
        chk($sformatf("hold%0d_rdata", c), bus.rsp_rdata, 32'hDE22_BE44);
        chk($sformatf("hold%0d_err", c), 32'(bus.rsp_err), 32'd0);
        chk($sformatf("hold%0d_req_ready", c), 32'(bus.req_ready), 32'd0);
      end
      bus.rsp_ready = 1'b1;
      complete("hold");
    end
    bus.rsp_ready = 1'b1;

    // Reset while a write waits: the write must never land.
    bus.req_valid = 1'b1;
    bus.req_wen   = 1'b1;
    bus.req_addr  = 32'h8000_0020;
    bus.req_wdata = 32'hCAFE_F00D;
    bus.req_wstrb = 4'hF;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rstwait_in_wait", 32'(bus.rsp_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstwait_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk("rstwait_req_ready", 32'(bus.req_ready), 32'd1);
    issue(1'b0, 32'h8000_0020, 32'h0, 4'h0, lat, rd, err, ok);
    if (ok) begin
      chk("rstwait_readback", rd, 32'h0);
      chk("rstwait_err", 32'(err), 32'd0);
      complete("rstwait");
    end

`ifdef DMEM_RAND_DELAY_EN
    begin
      logic [31:0] seen = '0;
      int          distinct = 0;
      for (int n = 0; n < 64; n++) begin
        logic [31:0] a;
        logic [31:0] e;
        a = (n % 2 == 0) ? 32'h8000_0010 : 32'h8000_3FFC;
        e = (n % 2 == 0) ? 32'hDE22_BE44 : 32'hAABB_CCDD;
        issue(1'b0, a, 32'h0, 4'h0, lat, rd, err, ok);
        if (ok) begin
          chk($sformatf("rand%0d_latency", n), 32'(lat >= 2 && lat <= 5), 32'd1);
          chk($sformatf("rand%0d_rdata", n), rd, e);
          if (lat < 32) seen[lat] = 1'b1;
          @(posedge clk);
          @(negedge clk);
        end
      end
      for (int b = 0; b < 32; b++) if (seen[b]) distinct++;
      chk("rand_distinct_ge2", 32'(distinct >= 2), 32'd1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Memory-side responder for the core's load/store unit: the target end of the data-memory request/response interface. Accepts one request at a time over a valid/ready request channel and performs the read or byte-masked write on an internal word array. Returns the result over a valid/ready response channel after a programmable latency. Used in simulation and FPGA builds to exercise the core's multi-cycle memory handshake.

Parameters:
DATA_W, 32, data and address width in bits
DEPTH_LOG2, 12, log2 of array depth in words (4096 words = 16 KiB)
BASE_ADDR, 32'h8000_0000, byte address of word 0
LATENCY, 2, cycles from request accept edge to rsp_valid high; legal range 1..15

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_wen  in  1  1 = write, 0 = read
req_addr  in  DATA_W  byte address; bits [1:0] ignored
req_wdata  in  DATA_W  write data, lane-aligned
req_wstrb  in  4  byte-lane write enables; bit i covers byte i
rsp_valid  out  1  response present
rsp_ready  in  1  requester accepts response
rsp_rdata  out  DATA_W  read data; 0 for writes and errors
rsp_err  out  1  address outside [BASE_ADDR, BASE_ADDR + 4*2^DEPTH_LOG2)

Behaviour:
- Reset: state IDLE; req_ready=1 in the cycle after reset deasserts; rsp_valid=0, rsp_rdata=0, rsp_err=0; wait counter=0. Array contents are not reset.
- Reset mid-operation: pending request dropped; a write not yet committed is never committed; rsp_valid is 0 in the next cycle.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, capture wen/addr/wdata/wstrb.
  - LATENCY==1: go to RESP.
  - Otherwise: load counter with LATENCY-2 and go to WAIT.
- WAIT: req_ready=0. Decrement the counter each cycle. At 0, go to RESP.
- Transition into RESP (single edge): compute word index = (addr - BASE_ADDR) >> 2, truncated to DEPTH_LOG2 bits.
  - In-range write: update the enabled lanes only. rsp_rdata=0, rsp_err=0.
  - In-range read: rsp_rdata = array word. rsp_err=0.
  - Out of range: no array access; rsp_rdata=0, rsp_err=1.
  - rsp_valid rises the same edge.
- RESP: rsp_valid=1; rsp_rdata and rsp_err held stable until the handshake. req_ready=0.
  - On rsp_valid&&rsp_ready: go to IDLE; rsp_valid=0 next cycle.
- Timing: rsp_valid is first high exactly LATENCY cycles after the accept edge. With rsp_ready tied high, the minimum request spacing is LATENCY+1 cycles.
- No back-to-back overlap: req_ready is low from the accept edge until the cycle after the response handshake.
- Read-after-write to the same word returns the new data.
- Write with wstrb=4'b0000: no array change; normal response.
- Address arithmetic is unsigned DATA_W-bit. Addresses below BASE_ADDR wrap to large values and are reported out of range.
- Requester inputs are sampled only at the accept edge; later changes have no effect.

Optional Feature:
DMEM_RAND_DELAY_EN:
- Defined: add an 8-bit Fibonacci LFSR (taps 8,6,5,4), reset to 8'hA5, advancing every cycle. At each accept, effective latency = LATENCY + lfsr[1:0] (range LATENCY..LATENCY+3). It stresses the requester's handshake.
- Undefined: latency is fixed at LATENCY and the LFSR logic is absent.

Test Plan:
- Reset, then write addr 0x8000_0010, wdata 0xDEADBEEF, wstrb 4'hF; then read the same address (LATENCY=2, rsp_ready=1). Write rsp_valid is high 2 cycles after accept with rdata=0, err=0; the read returns 0xDEADBEEF.
- Partial write 0x1122_3344 with wstrb 4'b0101 over 0xDEADBEEF at the same address, then read. Read returns 0xDE22BE44.
- Read 0x7FFF_FFFC and read 0x8000_4000 (DEPTH_LOG2=12). Both return rsp_err=1, rdata=0; array unchanged, checked by re-reading 0x8000_0010.
- Hold rsp_ready=0 for 5 cycles during a read response. rsp_valid, rdata and err stay stable; req_ready=0 throughout. req_ready=1 the cycle after rsp_ready rises.
- Assert rst in the WAIT state of a write of 0xCAFEF00D to 0x8000_0020 (previously 0). rsp_valid=0 after reset; a subsequent read returns 0.
- With DMEM_RAND_DELAY_EN defined, issue 64 reads. Every latency lies in 2..5, at least two distinct values occur, and all data is correct.
